vga_timing_gen: RTL

Parametrised VGA raster timing generator: the next generation of the team's fixed 640x480 timing block. It produces sync, data-enable and pixel coordinates for any mode via parameters, with an on-chip pixel-clock-enable divider, configurable sync polarity, a run/pause input and frame/line strobes. It sits between the system clock and the sprite/tile renderers (e.g. the snake generator), which consume `x_vga`, `y_vga` and `pix_ce`.

---
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing (sync, data enable, pixel coordinates).
// Latency: outputs are registered and describe the position entered on the tick edge; strobes last one clk.
// Backpressure: none; en=0 freezes divider, position and outputs, and it resumes where it stopped.
// Optional: define VGA_FRAME_CNT_EN to add a 16-bit frame counter output frame_cnt.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CLK_DIV  = 4,
  parameter int   COORD_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               HS,
  output logic               VS,
  output logic               Vde,
  output logic [COORD_W-1:0] x_vga,
  output logic [COORD_W-1:0] y_vga,
  output logic               pix_ce,
  output logic               line_start,
  output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Reject modes whose totals do not fit the coordinate width, and a zero divider.
  if ((longint'(H_TOTAL) > (longint'(1) << COORD_W)) ||
      (longint'(V_TOTAL) > (longint'(1) << COORD_W))) begin : g_bad_coord_w
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2**COORD_W");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  logic [DIV_W-1:0]   div;
  logic               tick;
  logic [COORD_W-1:0] h_nxt;
  logic [COORD_W-1:0] v_nxt;
  logic               hs_act;
  logic               vs_act;

  assign tick = en & (div == DIV_LAST);

  // Pixel-clock-enable divider; holds while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else if (en) begin
      div <= div + 1'b1;
    end
  end

  // Next raster position: h advances on tick, v advances when h wraps.
  always_comb begin
    h_nxt = x_vga;
    v_nxt = y_vga;
    if (tick) begin
      if (x_vga == H_LAST) begin
        h_nxt = '0;
        v_nxt = (y_vga == V_LAST) ? '0 : y_vga + 1'b1;
      end else begin
        h_nxt = x_vga + 1'b1;
      end
    end
  end

  // Sync windows decoded from the next position so they register alongside it.
  always_comb begin
    hs_act = (h_nxt >= HS_START) && (h_nxt < HS_END);
    vs_act = (v_nxt >= VS_START) && (v_nxt < VS_END);
  end

  // Position, sync, data enable and strobes, all registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_vga       <= H_LAST;
      y_vga       <= V_LAST;
      Vde         <= 1'b0;
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      pix_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x_vga       <= h_nxt;
      y_vga       <= v_nxt;
      Vde         <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      HS          <= hs_act ? HS_POL : ~HS_POL;
      VS          <= vs_act ? VS_POL : ~VS_POL;
      pix_ce      <= tick;
      line_start  <= tick && (h_nxt == '0);
      frame_start <= tick && (h_nxt == '0) && (v_nxt == '0);
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Frame counter steps on the same edge that raises frame_start, so it reads the new count then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (tick && (h_nxt == '0) && (v_nxt == '0)) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
